// File: rtl/bp_lite_to_burst_pkg.sv
// Shared definitions for the BedRock Lite-to-Burst converter.
//
// Header layout (LSB first): msg_type[3:0], subop[3:0], size[2:0], addr, payload.
// bp_me_burst_beats() converts a message size into a burst beat count.
package bp_lite_to_burst_pkg;

  localparam int unsigned MsgTypeW  = 4;
  localparam int unsigned SubopW    = 4;
  localparam int unsigned SizeW     = 3;
  localparam int unsigned MsgTypeLsb = 0;
  localparam int unsigned SizeLsb    = MsgTypeW + SubopW;

  typedef enum logic [SizeW-1:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  // Sub-beat sizes still need one beat; oversize messages saturate at the lite width.
  function automatic int unsigned bp_me_burst_beats(input logic [SizeW-1:0] size,
                                                    input int unsigned beat_bytes,
                                                    input int unsigned max_beats);
    int unsigned bytes;
    int unsigned beats;
    bytes = 32'd1 << size;
    beats = bytes / beat_bytes;
    if (beats == 0) beats = 1;
    if (beats > max_beats) beats = max_beats;
    return beats;
  endfunction

endpackage

// File: rtl/bp_lite_to_burst_serializer.sv
// Data-beat serializer: holds the wide lite data, walks a beat counter and flags
// the final beat.
//
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   load_i           capture data_i and the beat count for size_i; counter restarts at 0
//   data_i, size_i   wide lite data and its message size encoding
//   v_i, ready_i     beat valid (from the owner) and downstream ready
//   data_o           current beat, slice cnt of the stored data
//   last_o           current beat is the final one
//   done_o           handshake on the final beat this cycle
module bp_lite_to_burst_serializer
  import bp_lite_to_burst_pkg::*;
#(
  parameter int unsigned in_data_width_p  = 512,
  parameter int unsigned out_data_width_p = 64
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        load_i,
  input  logic [in_data_width_p-1:0]  data_i,
  input  logic [SizeW-1:0]            size_i,
  input  logic                        v_i,
  input  logic                        ready_i,
  output logic [out_data_width_p-1:0] data_o,
  output logic                        last_o,
  output logic                        done_o
);

  localparam int unsigned MaxBeats  = in_data_width_p / out_data_width_p;
  localparam int unsigned BeatBytes = out_data_width_p / 8;
  localparam int unsigned CntW      = (MaxBeats > 1) ? $clog2(MaxBeats) : 1;

  logic [in_data_width_p-1:0] data_q, data_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [CntW-1:0]            last_idx_q, last_idx_d;
  logic                       hs;

  assign hs     = v_i & ready_i;
  assign last_o = (cnt_q == last_idx_q);
  assign done_o = hs & last_o;
  assign data_o = data_q[cnt_q * out_data_width_p +: out_data_width_p];

  always_comb begin
    data_d     = data_q;
    cnt_d      = cnt_q;
    last_idx_d = last_idx_q;
    if (load_i) begin
      // A load may coincide with the final handshake of the previous message.
      data_d     = data_i;
      cnt_d      = '0;
      last_idx_d = CntW'(bp_me_burst_beats(size_i, BeatBytes, MaxBeats) - 1);
    end else if (hs) begin
      cnt_d = last_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q     <= '0;
      cnt_q      <= '0;
      last_idx_q <= '0;
    end else begin
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      last_idx_q <= last_idx_d;
    end
  end

endmodule

// File: rtl/bp_lite_to_burst.sv
// BedRock Lite to BedRock Burst converter. A one-entry buffer holds the lite
// message; the header and the data beats then drain on independent channels.
//
// Ports:
//   clk_i, reset_i                 clock, synchronous active-high reset
//   in_msg_i/_v_i/_ready_and_o     lite message {header, data}, ready-valid-and
//   out_msg_header_o/_v_o/_ready_and_i  burst header channel
//   out_msg_has_data_o             message carries data (qualified by header valid)
//   out_msg_data_o/_v_o/_ready_and_i    burst data beat channel
//   out_msg_last_o                 final beat (qualified by data valid)
//
// Build option BP_LITE_TO_BURST_BYPASS_EN: input ready also rises in the cycle the
// buffer frees, giving back-to-back messages at the cost of a ready-to-ready
// combinational path. Undefined by default.
module bp_lite_to_burst
  import bp_lite_to_burst_pkg::*;
#(
  parameter int unsigned paddr_width_p    = 40,
  parameter int unsigned in_data_width_p  = 512,
  parameter int unsigned out_data_width_p = 64,
  parameter int unsigned payload_width_p  = 16,
  parameter logic [(1<<MsgTypeW)-1:0] payload_mask_p = '0,
  localparam int unsigned HdrW = payload_width_p + paddr_width_p + SizeW + SubopW + MsgTypeW,
  localparam int unsigned InMsgW = HdrW + in_data_width_p
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [InMsgW-1:0]           in_msg_i,
  input  logic                        in_msg_v_i,
  output logic                        in_msg_ready_and_o,
  output logic [HdrW-1:0]             out_msg_header_o,
  output logic                        out_msg_header_v_o,
  input  logic                        out_msg_header_ready_and_i,
  output logic                        out_msg_has_data_o,
  output logic [out_data_width_p-1:0] out_msg_data_o,
  output logic                        out_msg_data_v_o,
  input  logic                        out_msg_data_ready_and_i,
  output logic                        out_msg_last_o
);

  logic [HdrW-1:0]     header_q, header_d;
  logic                buf_v_q, buf_v_d;
  logic                has_data_q, has_data_d;
  logic                header_sent_q, header_sent_d;
  logic                data_sent_q, data_sent_d;

  logic [HdrW-1:0]     in_hdr;
  logic [MsgTypeW-1:0] in_msg_type;
  logic                in_has_data;
  logic                accept, header_hs, data_done, hdr_done, dat_done, free;

  assign in_hdr      = in_msg_i[InMsgW-1 -: HdrW];
  assign in_msg_type = in_hdr[MsgTypeLsb +: MsgTypeW];
  assign in_has_data = payload_mask_p[in_msg_type];

  assign out_msg_header_o   = header_q;
  assign out_msg_has_data_o = has_data_q;
  assign out_msg_header_v_o = buf_v_q & ~header_sent_q;
  assign out_msg_data_v_o   = buf_v_q & has_data_q & ~data_sent_q;

  assign header_hs = out_msg_header_v_o & out_msg_header_ready_and_i;
  // Both channels finished, counting handshakes completing this very cycle.
  assign hdr_done  = header_sent_q | header_hs;
  assign dat_done  = data_sent_q | data_done;
  assign free      = buf_v_q & hdr_done & dat_done;

`ifdef BP_LITE_TO_BURST_BYPASS_EN
  assign in_msg_ready_and_o = ~buf_v_q | free;
`else
  assign in_msg_ready_and_o = ~buf_v_q;
`endif

  assign accept = in_msg_v_i & in_msg_ready_and_o;

  bp_lite_to_burst_serializer #(
    .in_data_width_p (in_data_width_p),
    .out_data_width_p(out_data_width_p)
  ) u_serializer (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .load_i (accept),
    .data_i (in_msg_i[in_data_width_p-1:0]),
    .size_i (in_hdr[SizeLsb +: SizeW]),
    .v_i    (out_msg_data_v_o),
    .ready_i(out_msg_data_ready_and_i),
    .data_o (out_msg_data_o),
    .last_o (out_msg_last_o),
    .done_o (data_done)
  );

  always_comb begin
    header_d      = header_q;
    buf_v_d       = buf_v_q;
    has_data_d    = has_data_q;
    header_sent_d = header_sent_q;
    data_sent_d   = data_sent_q;
    if (accept) begin
      header_d      = in_hdr;
      buf_v_d       = 1'b1;
      has_data_d    = in_has_data;
      header_sent_d = 1'b0;
      // No-data messages never raise data valid.
      data_sent_d   = ~in_has_data;
    end else if (free) begin
      buf_v_d       = 1'b0;
      header_sent_d = 1'b0;
      data_sent_d   = 1'b0;
    end else begin
      header_sent_d = hdr_done;
      data_sent_d   = dat_done;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      header_q      <= '0;
      buf_v_q       <= 1'b0;
      has_data_q    <= 1'b0;
      header_sent_q <= 1'b0;
      data_sent_q   <= 1'b0;
    end else begin
      header_q      <= header_d;
      buf_v_q       <= buf_v_d;
      has_data_q    <= has_data_d;
      header_sent_q <= header_sent_d;
      data_sent_q   <= data_sent_d;
    end
  end

endmodule
